// File: rtl/morph_filter_kxk.sv
// Streaming binary morphology filter (erosion / dilation) over a KSIZE x KSIZE
// window with private 1-bit line buffers, per-frame bypass and line-overflow flag.
// Output for input pixel (r,c) is centred at (r-H, c-H); latency is 3 clk.
module morph_filter_kxk #(
    parameter int IMG_W = 640,
    parameter int KSIZE = 3,
    parameter int COL_W = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_mode,
    input  logic cfg_bypass,
    input  logic pre_frame_vsync,
    input  logic pre_frame_href,
    input  logic pre_frame_clken,
    input  logic pre_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit,
    output logic err_line_ovf
);
    localparam int N  = KSIZE - 1;
    localparam int RW = $clog2(KSIZE);
    localparam int AW = $clog2(IMG_W);

    // {vsync, href, clken} delay line; stage 0 doubles as the edge-detect history
    logic [2:0]       sync_q [3];
    logic [COL_W-1:0] col_cnt_q, col_eff, col_d;
    logic [RW-1:0]    row_cnt_q, row_eff, row_d;
    logic             mode_q, byp_q, err_q;
    logic             mode_eff, byp_eff, err_d;
    logic             frame_start, href_fall, pix_valid, ovf_pix, wr_en;
    logic [AW-1:0]    addr;

    // S1 side-band: position of the pixel currently held in the window
    logic [COL_W-1:0] s1_col_q;
    logic [RW-1:0]    s1_row_q;
    logic             s1_ovf_q, s1_mode_q, s1_byp_q, s1_pix_q;
    // S2 side-band
    logic [KSIZE-1:0] row_red, row_res_q;
    logic             s2_ovf_q, s2_mode_q, s2_byp_q, s2_pix_q;
    logic             img_q;

    logic [KSIZE-1:0] new_bit;   // newest tap per window row: row r-k
    logic [N-1:0]     lb_rd;
    logic [KSIZE-1:0] col_ok;
    logic [KSIZE-1:0] pad;

    assign frame_start = pre_frame_vsync & ~sync_q[0][2];
    assign href_fall   = sync_q[0][1] & ~pre_frame_href;
    assign pix_valid   = pre_frame_href & pre_frame_clken;

    // A frame start in the same clk as a pixel makes that pixel row 0, col 0
    assign col_eff  = frame_start ? '0 : col_cnt_q;
    assign row_eff  = frame_start ? '0 : row_cnt_q;
    assign mode_eff = frame_start ? cfg_mode : mode_q;
    assign byp_eff  = frame_start ? cfg_bypass : byp_q;
    assign ovf_pix  = pix_valid && (col_eff == COL_W'(IMG_W));
    assign wr_en    = pix_valid && !ovf_pix;
    assign addr     = col_eff[AW-1:0];

    // Next-state of the line/column counters and the sticky overflow flag
    always_comb begin
        col_d = col_eff;
        if (href_fall && !frame_start)
            col_d = '0;
        else if (wr_en)
            col_d = col_eff + COL_W'(1);
        row_d = row_eff;
        if (!frame_start && href_fall && (col_cnt_q != '0) && (row_cnt_q != RW'(N)))
            row_d = row_cnt_q + RW'(1);
        err_d = frame_start ? 1'b0 : (err_q | ovf_pix);
    end

    // Counters, per-frame configuration latches and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            mode_q    <= 1'b0;
            byp_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            col_cnt_q <= col_d;
            row_cnt_q <= row_d;
            mode_q    <= mode_eff;
            byp_q     <= byp_eff;
            err_q     <= err_d;
        end
    end

    // Sync signals travel through a 3-deep delay matching the data pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q[0] <= '0;
            sync_q[1] <= '0;
            sync_q[2] <= '0;
        end else begin
            sync_q[0] <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
            sync_q[1] <= sync_q[0];
            sync_q[2] <= sync_q[1];
        end
    end

    assign new_bit[0] = pre_img_bit;

    // Line buffer k holds row r-1-k; read-before-write cascades the column downward.
    // The window's newest tap acts as the registered read of each buffer.
    for (genvar gi = 0; gi < N; gi++) begin : g_lb
        logic mem_q [IMG_W];
        assign lb_rd[gi]      = mem_q[addr];
        assign new_bit[gi+1]  = lb_rd[gi];
        // Vertical shift at the current column; content is never reset
        always_ff @(posedge clk) begin
            if (wr_en)
                mem_q[addr] <= new_bit[gi];
        end
    end

    // S1 side-band: capture pixel position on valid pixels, mode/bypass every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            s1_ovf_q  <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_byp_q  <= 1'b0;
            s1_pix_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                s1_col_q <= col_eff;
                s1_row_q <= row_eff;
            end
            s1_ovf_q  <= ovf_pix;
            s1_mode_q <= mode_eff;
            s1_byp_q  <= byp_eff;
            s1_pix_q  <= pre_img_bit;
        end
    end

    // Tap of age j is column c-j; it exists only if j <= c
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_colok
        assign col_ok[gi] = (COL_W'(gi) <= s1_col_q);
    end

    assign pad = {KSIZE{~s1_mode_q}};

    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        logic [KSIZE-1:0] win_q, msk, taps;
        // S1: window row shifts one column per accepted pixel, holds otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                win_q <= '0;
            else if (wr_en)
                win_q <= {win_q[KSIZE-2:0], new_bit[gi]};
        end
        // Rows above the frame top and columns left of the line start read neutral
        assign msk         = (RW'(gi) <= s1_row_q) ? col_ok : '0;
        assign taps        = (win_q & msk) | (pad & ~msk);
        assign row_red[gi] = s1_mode_q ? (|taps) : (&taps);
    end

    // S2: register per-row reductions and side-band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_res_q <= '0;
            s2_ovf_q  <= 1'b0;
            s2_mode_q <= 1'b0;
            s2_byp_q  <= 1'b0;
            s2_pix_q  <= 1'b0;
        end else begin
            row_res_q <= row_red;
            s2_ovf_q  <= s1_ovf_q;
            s2_mode_q <= s1_mode_q;
            s2_byp_q  <= s1_byp_q;
            s2_pix_q  <= s1_pix_q;
        end
    end

    // S3: combine row results; overflow pixels give neutral, bypass gives raw pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            img_q <= 1'b0;
        else if (s2_byp_q)
            img_q <= s2_pix_q;
        else if (s2_ovf_q)
            img_q <= ~s2_mode_q;
        else
            img_q <= s2_mode_q ? (|row_res_q) : (&row_res_q);
    end

    assign post_frame_vsync = sync_q[2][2];
    assign post_frame_href  = sync_q[2][1];
    assign post_frame_clken = sync_q[2][0];
    assign post_img_bit     = img_q;
    assign err_line_ovf     = err_q;

endmodule

// File: tb/tb_morph_filter_kxk.sv
// Scoreboard bench for morph_filter_kxk: K=3 and K=5 instances share stimulus;
// expected pixels are queued at issue time and popped by per-instance monitors.
module tb_morph_filter_kxk;
    localparam int IMG_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_mode = 1'b0, cfg_bypass = 1'b0;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0, pix = 1'b0;
    logic v3, h3, c3, b3, e3;
    logic v5, h5, c5, b5, e5;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct { logic val; int r; int c; } exp_t;
    exp_t q3[$];
    exp_t q5[$];
    logic [2:0] hist [3];

    always #5 clk = ~clk;

    morph_filter_kxk #(.IMG_W(IMG_W), .KSIZE(3), .COL_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_bypass(cfg_bypass),
        .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_clken(clken),
        .pre_img_bit(pix), .post_frame_vsync(v3), .post_frame_href(h3),
        .post_frame_clken(c3), .post_img_bit(b3), .err_line_ovf(e3));

    morph_filter_kxk #(.IMG_W(IMG_W), .KSIZE(5), .COL_W(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_bypass(cfg_bypass),
        .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_clken(clken),
        .pre_img_bit(pix), .post_frame_vsync(v5), .post_frame_href(h5),
        .post_frame_clken(c5), .post_img_bit(b5), .err_line_ovf(e5));

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        total_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    endtask

    // Input pattern per test kind
    function automatic logic pat(input int kind, input int r, input int c);
        case (kind)
            1, 7:    return 1'b1;
            2:       return !(r == 3 && c == 3);
            3:       return (r == 2 && c == 2);
            default: return 1'b0;
        endcase
    endfunction

    // Expected output for input pixel (r,c): window covers rows r-k+1..r, cols c-k+1..c
    function automatic logic exp_k(input int k, input int kind, input int r, input int c, input logic p);
        int s;
        s = k - 1;
        case (kind)
            1, 7:    return 1'b1;
            2:       return !(r >= 3 && r <= 3 + s && c >= 3 && c <= 3 + s);
            3:       return (r >= 2 && r <= 2 + s && c >= 2 && c <= 2 + s);
            4:       return p;
            6:       return (c >= IMG_W);
            default: return 1'b0;
        endcase
    endfunction

    // Expected sync history, cleared by reset just like the DUT delay line
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
        end else begin
            hist[0] <= {vsync, href, clken};
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    // Monitor: sync delay for both instances
    always @(negedge clk) begin
        if (rst_n) begin
            check("sync3", {v3, h3, c3}, hist[2]);
            check("sync5", {v5, h5, c5}, hist[2]);
        end
    end

    // Monitor: K=3 output pixels
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && h3 && c3) begin
            if (q3.size() == 0) begin
                total_cnt++;
                $display("FAIL pix3 unexpected output actual=%b required=none", b3);
            end else begin
                e = q3.pop_front();
                if (b3 !== e.val)
                    $display("pix3 r%0d c%0d:", e.r, e.c);
                check("pix3", {2'b0, b3}, {2'b0, e.val});
            end
        end
    end

    // Monitor: K=5 output pixels
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && h5 && c5) begin
            if (q5.size() == 0) begin
                total_cnt++;
                $display("FAIL pix5 unexpected output actual=%b required=none", b5);
            end else begin
                e = q5.pop_front();
                if (b5 !== e.val)
                    $display("pix5 r%0d c%0d:", e.r, e.c);
                check("pix5", {2'b0, b5}, {2'b0, e.val});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0; clken = 1'b0;
        end
    endtask

    task automatic frame_start(input logic mode, input logic byp);
        @(negedge clk);
        cfg_mode = mode; cfg_bypass = byp;
        vsync = 1'b1; href = 1'b0; clken = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        idle(2);
    endtask

    task automatic send_line(input int kind, input int r, input int cols, input bit gap);
        logic p;
        exp_t e;
        for (int c = 0; c < cols; c++) begin
            if (gap) begin
                repeat ($urandom_range(0, 1)) begin
                    @(negedge clk);
                    href = 1'b1; clken = 1'b0; pix = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            if (kind == 6 && c > 0) begin
                check("err3", {2'b0, e3}, {2'b0, c > IMG_W});
                check("err5", {2'b0, e5}, {2'b0, c > IMG_W});
            end
            p = (kind == 4) ? 1'($urandom_range(0, 1)) : pat(kind, r, c);
            href = 1'b1; clken = 1'b1; pix = p;
            e.r = r; e.c = c;
            e.val = exp_k(3, kind, r, c, p); q3.push_back(e);
            e.val = exp_k(5, kind, r, c, p); q5.push_back(e);
        end
    endtask

    task automatic send_frame(input int kind, input int rows, input bit gap,
                              input logic mode, input logic byp, input int toggle_row);
        frame_start(mode, byp);
        for (int r = 0; r < rows; r++) begin
            if (r == toggle_row) cfg_mode = ~cfg_mode;
            send_line(kind, r, IMG_W, gap);
            idle(3);
        end
        idle(6);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst3", {v3, h3, c3}, 3'b000);
        check("rst5", {v5, h5, c5}, 3'b000);
        check("rst_bit", {1'b0, b3, b5}, 3'b000);
        check("rst_err", {1'b0, e3, e5}, 3'b000);
        @(negedge clk); rst_n = 1'b1;
        idle(3);

        $display("T1 erosion all ones");
        send_frame(1, 6, 1'b0, 1'b0, 1'b0, -1);
        $display("T2/T5 erosion single zero, mode toggled mid-frame");
        send_frame(2, 6, 1'b0, 1'b0, 1'b0, 2);
        $display("T3/T5 dilation single one, clken gaps, mode toggled mid-frame");
        send_frame(3, 8, 1'b1, 1'b1, 1'b0, 3);
        $display("T4 bypass random");
        send_frame(4, 4, 1'b1, 1'b0, 1'b1, -1);

        $display("T6 line overflow");
        frame_start(1'b0, 1'b0);
        send_line(6, 0, IMG_W + 2, 1'b0);
        @(negedge clk);
        href = 1'b0; clken = 1'b0;
        check("err3_hold", {2'b0, e3}, 3'b001);
        check("err5_hold", {2'b0, e5}, 3'b001);
        idle(6);
        check("err3_still", {2'b0, e3}, 3'b001);
        frame_start(1'b0, 1'b0);
        check("err3_clr", {2'b0, e3}, 3'b000);
        check("err5_clr", {2'b0, e5}, 3'b000);
        send_line(6, 0, IMG_W + 2, 1'b0);

        $display("T6 reset mid-frame");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst3", {v3, h3, c3}, 3'b000);
        check("mrst5", {v5, h5, c5}, 3'b000);
        check("mrst_bit", {1'b0, b3, b5}, 3'b000);
        check("mrst_err", {1'b0, e3, e5}, 3'b000);
        q3.delete(); q5.delete();
        href = 1'b0; clken = 1'b0; pix = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle(3);
        // Rows after reset must pad over stale line-buffer zeros
        send_line(7, 0, IMG_W, 1'b0);
        idle(3);
        send_line(7, 1, IMG_W, 1'b0);
        idle(8);

        check("q3_empty", {2'b0, q3.size() == 0}, 3'b001);
        check("q5_empty", {2'b0, q5.size() == 0}, 3'b001);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
